// File: rtl/chs_thermo_scheduler.sv
// Closed-loop cool/heat sequencer: hysteresis mode select, reversal dead-time and ramped fan speed.
// Optional sample watchdog with FAULT state enabled by defining CHS_SCHED_WDOG_EN.
module chs_thermo_scheduler #(
    parameter int unsigned HYST      = 2,
    parameter int unsigned GAIN      = 4,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned RAMP_DIV  = 4,
    parameter int unsigned DEAD_CYC  = 8
`ifdef CHS_SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC  = 1024
`endif
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic [7:0] temp_set,
    input  logic [7:0] temp_cur,
    input  logic       sample_valid,
    output logic [7:0] speed,
    output logic [7:0] chs_conf,
    output logic [2:0] ctrl_state,
    output logic       fault
);
    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COOL  = 3'd1,
        S_HEAT  = 3'd2,
        S_DEAD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        D_NONE = 2'd0,
        D_COOL = 2'd1,
        D_HEAT = 2'd2
    } dir_t;

    function automatic logic [7:0] sat_u8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    // Move toward tgt by at most RAMP_STEP without overshooting or wrapping.
    function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        logic [7:0] step;
        diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        step = (diff > 8'(RAMP_STEP)) ? 8'(RAMP_STEP) : diff;
        return (tgt > cur) ? (cur + step) : (cur - step);
    endfunction

    state_t            state_q, state_d;
    dir_t              last_dir_q, last_dir_d;
    logic [7:0]        temp_q, temp_d;
    logic [7:0]        speed_q, speed_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DEAD_W-1:0] dead_q, dead_d;

    logic       hot, cold, tick;
    logic [7:0] err, target;

    always_comb begin
        hot    = {1'b0, temp_q} > ({1'b0, temp_set} + 9'(HYST));
        cold   = ({1'b0, temp_q} + 9'(HYST)) < {1'b0, temp_set};
        err    = (temp_q >= temp_set) ? (temp_q - temp_set) : (temp_set - temp_q);
        target = 8'd0;
        if (state_q == S_COOL || state_q == S_HEAT)
            target = sat_u8(16'(err) * 16'(GAIN));
        tick    = (pre_q == PRE_W'(RAMP_DIV - 1));
        pre_d   = tick ? '0 : pre_q + 1'b1;
        speed_d = tick ? ramp_to(speed_q, target) : speed_q;
        temp_d  = sample_valid ? temp_cur : temp_q;
    end

`ifdef CHS_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_to;

    always_comb begin
        wdog_to = (wdog_q >= WDOG_W'(WDOG_CYC));
        wdog_d  = sample_valid ? '0 : (wdog_to ? wdog_q : wdog_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (arst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        dead_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (enable && hot) begin
                    if (last_dir_q == D_HEAT) state_d = S_DEAD;
                    else begin
                        state_d    = S_COOL;
                        last_dir_d = D_COOL;
                    end
                end else if (enable && cold) begin
                    if (last_dir_q == D_COOL) state_d = S_DEAD;
                    else begin
                        state_d    = S_HEAT;
                        last_dir_d = D_HEAT;
                    end
                end
            end
            S_COOL: begin
                if (!enable)                state_d = S_IDLE;
                else if (cold)              state_d = S_DEAD;
                else if (temp_q <= temp_set) state_d = S_IDLE;
            end
            S_HEAT: begin
                if (!enable)                state_d = S_IDLE;
                else if (hot)               state_d = S_DEAD;
                else if (temp_q >= temp_set) state_d = S_IDLE;
            end
            S_DEAD: begin
                // Dead-time only starts counting once the fan has fully spun down.
                if (speed_q != 8'd0) dead_d = '0;
                else if (dead_q == DEAD_W'(DEAD_CYC - 1)) begin
                    state_d    = S_IDLE;
                    last_dir_d = D_NONE;
                end else dead_d = dead_q + 1'b1;
            end
`ifdef CHS_SCHED_WDOG_EN
            S_FAULT: begin
                if (sample_valid && speed_q == 8'd0) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef CHS_SCHED_WDOG_EN
        if (wdog_to && state_q != S_FAULT) begin
            state_d = S_FAULT;
            dead_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q    <= S_IDLE;
            last_dir_q <= D_NONE;
            temp_q     <= 8'd0;
            speed_q    <= 8'd0;
            pre_q      <= '0;
            dead_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            temp_q     <= temp_d;
            speed_q    <= speed_d;
            pre_q      <= pre_d;
            dead_q     <= dead_d;
        end
    end

    assign speed      = speed_q;
    assign chs_conf   = temp_q;
    assign ctrl_state = state_q;
`ifdef CHS_SCHED_WDOG_EN
    assign fault = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_chs_thermo_scheduler.sv
// Directed-vector bench for chs_thermo_scheduler with hand-computed expectations (default parameters).
module tb_chs_thermo_scheduler;
    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] temp_set = 8'd0;
    logic [7:0] temp_cur = 8'd0;
    logic       sample_valid = 1'b0;
    logic [7:0] speed;
    logic [7:0] chs_conf;
    logic [2:0] ctrl_state;
    logic       fault;

    int vec_cnt = 0;
    int err_cnt = 0;

    chs_thermo_scheduler dut (
        .clk         (clk),
        .arst        (arst),
        .enable      (enable),
        .temp_set    (temp_set),
        .temp_cur    (temp_cur),
        .sample_valid(sample_valid),
        .speed       (speed),
        .chs_conf    (chs_conf),
        .ctrl_state  (ctrl_state),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end, want completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [7:0] t);
        sample_valid = 1'b1;
        temp_cur     = t;
        cyc(1);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        cyc(1);
        arst = 1'b0;
    endtask

    initial begin
        // Edge counts below are relative to the reset edge (e0); ramp ticks land on e4, e8, ...
        temp_set = 8'd25;
        do_reset();
        chk("rst_speed", speed, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_conf", chs_conf, 0);
        chk("rst_fault", fault, 0);

        sample(8'd25);                       // e1
        enable = 1'b1;
        cyc(1);                              // e2
        chk("idle_at_set", ctrl_state, 0);
        sample(8'd26); cyc(1);               // e4
        chk("idle_26", ctrl_state, 0);
        sample(8'd27); cyc(1);               // e6
        chk("idle_27", ctrl_state, 0);
        sample(8'd28);                       // e7
        chk("latch_edge_still_idle", ctrl_state, 0);
        cyc(1);                              // e8
        chk("cool_28", ctrl_state, 1);
        chk("conf_28", chs_conf, 28);

        sample(8'd30);                       // e9, target 20
        cyc(2);  chk("ramp_pre_tick", speed, 0);     // e11
        cyc(1);  chk("ramp_tick1", speed, 16);       // e12
        cyc(3);  chk("ramp_hold", speed, 16);        // e15
        cyc(1);  chk("ramp_tick2", speed, 20);       // e16
        cyc(4);  chk("ramp_at_target", speed, 20);   // e20
        chk("cool_held", ctrl_state, 1);

        sample(8'd20);                       // e21
        chk("cool_until_used", ctrl_state, 1);
        cyc(1);  chk("cool_to_dead", ctrl_state, 3); // e22
        cyc(2);  chk("dead_ramp_4", speed, 4);       // e24
        cyc(4);  chk("dead_ramp_0", speed, 0);       // e28
        cyc(7);  chk("dead_hold", ctrl_state, 3);    // e35
        cyc(1);  chk("dead_to_idle", ctrl_state, 0); // e36
        cyc(1);  chk("idle_to_heat", ctrl_state, 2); // e37
        cyc(3);  chk("heat_tick1", speed, 16);       // e40
        cyc(4);  chk("heat_tick2", speed, 20);       // e44

        enable = 1'b0;
        cyc(1);  chk("disable_to_idle", ctrl_state, 0); // e45
        sample(8'd30);                                   // e46
        enable = 1'b1;
        cyc(1);  chk("reverse_via_dead", ctrl_state, 3); // e47
        chk("speed_before_tick", speed, 20);
        cyc(1);  chk("reverse_ramp", speed, 4);          // e48
        enable = 1'b0;
        cyc(1);  chk("dead_ignores_enable", ctrl_state, 3); // e49
        cyc(11); chk("dead_done_disabled", ctrl_state, 0);  // e60
        cyc(1);  chk("idle_stays_disabled", ctrl_state, 0); // e61
        enable = 1'b1;
        cyc(1);  chk("reenable_cool", ctrl_state, 1);       // e62
        chk("fault_low", fault, 0);

        // Saturated target and reset mid-ramp.
        temp_set = 8'd0;
        do_reset();
        sample(8'd200);                      // e1
        enable = 1'b1;
        cyc(1);  chk("sat_cool", ctrl_state, 1);     // e2
        cyc(10); chk("sat_speed48", speed, 48);      // e12
        arst = 1'b1;
        cyc(1);
        arst = 1'b0;
        chk("midramp_rst_speed", speed, 0);
        chk("midramp_rst_state", ctrl_state, 0);
        chk("midramp_rst_conf", chs_conf, 0);

        sample(8'd200);                      // e1
        cyc(1);                              // e2
        for (int k = 1; k <= 17; k++) begin
            cyc((k == 1) ? 2 : 4);
            chk($sformatf("sat_tick%0d", k), speed, (16 * k > 255) ? 16'd255 : 16'(16 * k));
        end
        chk("sat_conf", chs_conf, 200);

`ifdef CHS_SCHED_WDOG_EN
        temp_set = 8'd0;
        do_reset();
        enable = 1'b1;
        cyc(1100);
        chk("wdog_fault", fault, 1);
        chk("wdog_state", ctrl_state, 4);
        chk("wdog_speed", speed, 0);
        sample(8'd50);
        chk("wdog_exit_state", ctrl_state, 0);
        chk("wdog_exit_fault", fault, 0);
        chk("wdog_exit_conf", chs_conf, 50);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
